// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide initiator and its core.
//   op_e    : cmd_op encodings accepted from the control unit
//   state_e : hilo_sequencer FSM states
//   CORE_LATENCY_DEF : default core latency in cycles from core start
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_MTHI = 2'd2,
    OP_MTLO = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int unsigned CORE_LATENCY_DEF = 34;

endpackage

// File: rtl/hilo_sequencer.sv
// Initiator for the multicycle multiply/divide core; owns architectural HI/LO.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake from control unit
//   cmd_op, rs_val, rt_val  : command opcode and operands
//   busy, done, div_zero_exc: status; done/div_zero_exc are one-cycle pulses
//   hi_q, lo_q              : architectural HI/LO
//   core_sel, core_reset    : core mode (1=mult) and start/clear
//   core_a, core_b          : latched operands to the core
//   core_high, core_low, core_div_zero : core results
module hilo_sequencer
  import mult_div_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = CORE_LATENCY_DEF,
  parameter int unsigned CNT_W        = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        core_sel,
  output logic        core_reset,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_high,
  input  logic [31:0] core_low,
  input  logic        core_div_zero
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               exc_flag;
  op_e                op;

  assign op = op_e'(cmd_op);

  // Status is decoded from registered state; reset masks it immediately so
  // nothing is advertised during the cycle reset is applied.
  assign cmd_ready    = ~reset & (state == ST_IDLE);
  assign busy         = ~reset & (state != ST_IDLE);
  assign done         = ~reset & (state == ST_COMMIT);
  assign div_zero_exc = ~reset & (state == ST_COMMIT) & exc_flag;
  // The core is held cleared outside WAIT; it starts when WAIT is entered.
  assign core_reset   = reset | (state != ST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      core_a   <= '0;
      core_b   <= '0;
      core_sel <= 1'b0;
      cnt      <= '0;
      exc_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_MULT, OP_DIV: begin
                core_a   <= rs_val;
                core_b   <= rt_val;
                core_sel <= (op == OP_MULT);
                state    <= ST_LAUNCH;
              end
              OP_MTHI: begin
                hi_q  <= rs_val;
                state <= ST_COMMIT;
              end
              OP_MTLO: begin
                lo_q  <= rs_val;
                state <= ST_COMMIT;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_LAUNCH: begin
          cnt   <= CNT_W'(CORE_LATENCY - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            // core_sel doubles as the latched opcode: 1=MULT, 0=DIV.
            if (core_sel) begin
              hi_q <= core_high;
              lo_q <= core_low;
            end else if (core_div_zero) begin
              exc_flag <= 1'b1;
            end else begin
              lo_q <= core_high;
              hi_q <= core_low;
            end
            state <= ST_COMMIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_COMMIT: begin
          exc_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
module tb_hilo_sequencer;
  import mult_div_pkg::*;

  localparam int unsigned LAT = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_zero_exc;
  logic [31:0] hi_q, lo_q;
  logic        core_sel, core_reset;
  logic [31:0] core_a, core_b;
  logic [31:0] core_high, core_low;
  logic        core_div_zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  hilo_sequencer #(.CORE_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
    .done(done), .div_zero_exc(div_zero_exc), .hi_q(hi_q), .lo_q(lo_q),
    .core_sel(core_sel), .core_reset(core_reset), .core_a(core_a),
    .core_b(core_b), .core_high(core_high), .core_low(core_low),
    .core_div_zero(core_div_zero)
  );

  // Core stand-in: results only become correct LAT cycles after start;
  // before that it drives inverted values so an early commit is visible.
  int unsigned core_cnt;
  always_ff @(posedge clk) begin
    if (core_reset) core_cnt <= 0;
    else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
  end

  always_comb begin
    logic [63:0] prod;
    logic [31:0] quo, rem, hv, lv;
    logic        rdy, dz;
    prod = $signed({{32{core_a[31]}}, core_a}) * $signed({{32{core_b[31]}}, core_b});
    dz = (core_b == 32'd0);
    if (dz) begin
      quo = '1; rem = core_a;
    end else if (core_a == 32'h8000_0000 && core_b == 32'hFFFF_FFFF) begin
      quo = core_a; rem = '0;
    end else begin
      quo = $signed(core_a) / $signed(core_b);
      rem = $signed(core_a) % $signed(core_b);
    end
    hv  = core_sel ? prod[63:32] : quo;
    lv  = core_sel ? prod[31:0]  : rem;
    rdy = (core_cnt >= LAT - 1);
    core_high     = rdy ? hv : ~hv;
    core_low      = rdy ? lv : ~lv;
    core_div_zero = rdy ? dz : ~dz;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  // Architectural effect of a command, from the instruction semantics.
  task automatic ref_apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a; sb = b;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      OP_DIV: if (b != 0) begin
        exp_lo = sa / sb;
        exp_hi = sa % sb;
      end
      OP_MTHI: exp_hi = a;
      default: exp_lo = a;
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    check("ready_wait", {63'd0, cmd_ready}, 64'd1);
  endtask

  // Issue one command and follow it to completion. With hold set, cmd_valid
  // stays high and rs_val keeps changing while the command runs.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int k;
    bit busy_ok, opnd_ok, is_md, exp_exc;
    int exp_lat;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; rs_val = a; rt_val = b;
    step();
    if (!hold) cmd_valid = 1'b0;
    is_md   = (op == OP_MULT) || (op == OP_DIV);
    exp_exc = (op == OP_DIV) && (b == 32'd0);
    exp_lat = is_md ? int'(LAT) + 2 : 1;
    ref_apply(op, a, b);
    k = 1; busy_ok = 1'b1; opnd_ok = 1'b1;
    while (!done && k < 100) begin
      if (!busy || cmd_ready) busy_ok = 1'b0;
      if (is_md && (core_a !== a || core_b !== b || core_sel !== (op == OP_MULT))) opnd_ok = 1'b0;
      if (hold) rs_val = $urandom;
      step(); k++;
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_during_op", {63'd0, busy_ok}, 64'd1);
    if (is_md) begin
      check("operands_held", {63'd0, opnd_ok}, 64'd1);
      check("core_a_commit", {32'd0, core_a}, {32'd0, a});
    end
    check("ready_in_commit", {63'd0, cmd_ready}, 64'd0);
    check("exc_at_done", {63'd0, div_zero_exc}, {63'd0, exp_exc});
    check("hi_q", {32'd0, hi_q}, {32'd0, exp_hi});
    check("lo_q", {32'd0, lo_q}, {32'd0, exp_lo});
    step();
    check("done_one_cycle", {62'd0, done, div_zero_exc}, 64'd0);
    check("ready_after", {62'd0, cmd_ready, busy}, 64'd2);
  endtask

  initial begin
    bit saw_done;
    logic [31:0] a, b;
    logic [1:0]  op;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; rs_val = '0; rt_val = '0;
    step(); step();
    check("rst_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_core_reset", {63'd0, core_reset}, 64'd1);
    check("rst_status", {61'd0, busy, done, div_zero_exc}, 64'd0);
    check("rst_hilo", {hi_q, lo_q}, 64'd0);
    check("rst_core_opnd", {31'd0, core_sel, core_a ^ core_b, core_a}, 64'd0);
    reset = 1'b0;
    step();
    check("ready_idle", {63'd0, cmd_ready}, 64'd1);

    run(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mult_neg_const", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_const", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFFD);

    run(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    run(OP_MTLO, 32'h0000_5678, 32'd0, 1'b0);
    run(OP_DIV, 32'd10, 32'd0, 1'b0);
    check("divzero_keep", {hi_q, lo_q}, 64'h0000_1234_0000_5678);

    run(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run(OP_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0);
    check("mt_final", {hi_q, lo_q}, 64'hDEAD_BEEF_0BAD_F00D);

    // MULT by zero: core flags div-by-zero but it must be ignored.
    run(OP_MULT, 32'd123, 32'd0, 1'b0);

    // Requester holds cmd_valid with a changing rs_val during a command.
    run(OP_MULT, 32'h0001_0003, 32'h0000_0101, 1'b1);
    run(OP_DIV, 32'd1000, 32'd7, 1'b0);

    // Reset in WAIT cycle 10 of a MULT.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_MULT; rs_val = 32'h1234_5678; rt_val = 32'h0000_0099;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    check("midrst_ready", {63'd0, cmd_ready}, 64'd0);
    check("midrst_core_reset", {63'd0, core_reset}, 64'd1);
    check("midrst_status", {61'd0, busy, done, div_zero_exc}, 64'd0);
    step();
    check("midrst_hilo", {hi_q, lo_q}, 64'd0);
    check("midrst_core_a", {32'd0, core_a}, 64'd0);
    check("midrst_core_reset2", {63'd0, core_reset}, 64'd1);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    check("midrst_no_done", {63'd0, saw_done}, 64'd0);
    run(OP_MULT, 32'd5, 32'd6, 1'b0);
    check("mult_5x6", {hi_q, lo_q}, 64'd30);

    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run(op, a, b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
